// File: rtl/bundle_seq_pkg.sv
// bundle_seq_pkg: shared state type and HV memory address helper for the bundle element sequencer.
package bundle_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        GAP,
        WAIT_LOW,
        WAIT_RES,
        WRITE
    } BundleSeq_State_t;

    // Vector-major layout: all elements of vector v are contiguous.
    function automatic int unsigned hv_addr(input int unsigned v, input int unsigned e, input int unsigned dim);
        return v * dim + e;
    endfunction

endpackage

// File: rtl/bundle_element_sequencer_if.sv
// bundle_element_sequencer_if: control, HV memory read, bundler stream and result write signals.
interface bundle_element_sequencer_if #(
    parameter int HV_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH    = 16
);
    logic                     start;
    logic                     busy;
    logic                     done_all;
    logic                     err;
    logic                     mem_rd_en;
    logic [ADDR_WIDTH-1:0]    mem_addr;
    logic [HV_DATA_WIDTH-1:0] mem_rd_data;
    logic                     bnd_valid;
    logic                     bnd_first;
    logic                     bnd_last;
    logic [HV_DATA_WIDTH-1:0] bnd_data;
    logic                     bnd_ready;
    logic                     bnd_done;
    logic [HV_DATA_WIDTH-1:0] bnd_result;
    logic                     res_wr_en;
    logic [ADDR_WIDTH-1:0]    res_addr;
    logic [HV_DATA_WIDTH-1:0] res_data;

    modport master (
        input  start, mem_rd_data, bnd_ready, bnd_done, bnd_result,
        output busy, done_all, err, mem_rd_en, mem_addr,
               bnd_valid, bnd_first, bnd_last, bnd_data,
               res_wr_en, res_addr, res_data
    );

    modport slave (
        output start, mem_rd_data, bnd_ready, bnd_done, bnd_result,
        input  busy, done_all, err, mem_rd_en, mem_addr,
               bnd_valid, bnd_first, bnd_last, bnd_data,
               res_wr_en, res_addr, res_data
    );
endinterface

// File: rtl/bundle_element_sequencer.sv
// bundle_element_sequencer: streams element e of NUM_HV stored vectors into the bundler and writes each cut result to address e.
// Define BUNDLE_SEQ_TIMEOUT_EN to build the ISSUE/WAIT_LOW/WAIT_RES watchdog that raises err.
module bundle_element_sequencer
    import bundle_seq_pkg::*;
#(
    parameter int HV_DATA_WIDTH  = 32,
    parameter int NUM_HV         = 4,
    parameter int HV_DIM         = 64,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                        clk,
    input logic                        reset_n,
    bundle_element_sequencer_if.master bus
);
    localparam int VW = $clog2(NUM_HV);
    localparam int EW = HV_DIM > 1 ? $clog2(HV_DIM) : 1;

    if (NUM_HV < 2 || TIMEOUT_CYCLES < 1 ||
        longint'(NUM_HV) * longint'(HV_DIM) > (longint'(1) << ADDR_WIDTH)) begin : g_param_chk
        $error("bundle_element_sequencer: illegal NUM_HV/HV_DIM/ADDR_WIDTH/TIMEOUT_CYCLES");
    end

    BundleSeq_State_t         state_q, state_d;
    logic [VW-1:0]            v_q, v_d;
    logic [EW-1:0]            e_q, e_d;
    logic [HV_DATA_WIDTH-1:0] data_q, data_d;
    logic [HV_DATA_WIDTH-1:0] res_q, res_d;
    logic                     first_q, first_d;
    logic                     last_q, last_d;
    logic                     done_q, done_d;

`ifdef BUNDLE_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          timed;
    assign timed = state_q inside {ISSUE, WAIT_LOW, WAIT_RES};
`endif

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        e_d     = e_q;
        data_d  = data_q;
        res_d   = res_q;
        first_d = first_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:     state_d = bus.start ? FETCH : IDLE;
            FETCH:    state_d = LOAD;
            LOAD: begin
                data_d  = bus.mem_rd_data;
                first_d = v_q == '0;
                last_d  = v_q == VW'(NUM_HV - 1);
                state_d = ISSUE;
            end
            ISSUE:    state_d = bus.bnd_ready ? GAP : ISSUE;
            GAP: begin
                v_d     = v_q == VW'(NUM_HV - 1) ? v_q : v_q + 1'b1;
                state_d = v_q == VW'(NUM_HV - 1) ? WAIT_LOW : FETCH;
            end
            // The bundler drops done once it has taken the group; only then is a high done a fresh result.
            WAIT_LOW: state_d = bus.bnd_done ? WAIT_LOW : WAIT_RES;
            WAIT_RES: begin
                res_d   = bus.bnd_done ? bus.bnd_result : res_q;
                state_d = bus.bnd_done ? WRITE : WAIT_RES;
            end
            WRITE: begin
                v_d     = '0;
                done_d  = e_q == EW'(HV_DIM - 1);
                e_d     = e_q == EW'(HV_DIM - 1) ? '0 : e_q + 1'b1;
                state_d = e_q == EW'(HV_DIM - 1) ? IDLE : FETCH;
            end
            default:  state_d = IDLE;
        endcase
`ifdef BUNDLE_SEQ_TIMEOUT_EN
        err_d = (state_q == IDLE && bus.start) ? 1'b0 : err_q;
        if (timed && state_d == state_q && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            data_d  = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
            v_d     = '0;
            e_d     = '0;
            state_d = IDLE;
        end
        cnt_d = (timed && state_d == state_q) ? cnt_q + 1'b1 : '0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            v_q     <= '0;
            e_q     <= '0;
            data_q  <= '0;
            res_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BUNDLE_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            e_q     <= e_d;
            data_q  <= data_d;
            res_q   <= res_d;
            first_q <= first_d;
            last_q  <= last_d;
            done_q  <= done_d;
`ifdef BUNDLE_SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

`ifdef BUNDLE_SEQ_TIMEOUT_EN
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
    assign bus.busy      = state_q != IDLE;
    assign bus.done_all  = done_q;
    assign bus.mem_rd_en = state_q == FETCH;
    assign bus.mem_addr  = ADDR_WIDTH'(hv_addr(32'(v_q), 32'(e_q), HV_DIM));
    assign bus.bnd_valid = state_q == ISSUE && bus.bnd_ready;
    assign bus.bnd_first = first_q;
    assign bus.bnd_last  = last_q;
    assign bus.bnd_data  = data_q;
    assign bus.res_wr_en = state_q == WRITE;
    assign bus.res_addr  = ADDR_WIDTH'(e_q);
    assign bus.res_data  = res_q;

endmodule

// File: tb/tb_bundle_element_sequencer.sv
// tb_bundle_element_sequencer: directed bench with an HV memory and a sign-summing bundler model.
// Define BUNDLE_SEQ_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_bundle_element_sequencer;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam logic [31:0] P1 = 32'h3F80_0000;
    localparam logic [31:0] N1 = 32'hBF80_0000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ready_block = 1'b0;
    logic stuck = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   ok;

    bundle_element_sequencer_if #(.HV_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bundle_element_sequencer #(
        .HV_DATA_WIDTH(DW), .NUM_HV(4), .HV_DIM(2), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Layout addr = v*2 + e; element 0 sums to +2, element 1 to -2.
    logic [31:0] mem [8] = '{P1, N1, P1, P1, N1, N1, P1, N1};
    always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_addr[2:0]] : 32'hDEAD_BEEF;
    assign bus.bnd_ready = !ready_block;

    int acc;
    int dly;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.bnd_done   <= 1'b1;
            bus.bnd_result <= '0;
            acc <= 0;
            dly <= 0;
        end else if (bus.bnd_valid && bus.bnd_ready) begin
            acc <= (bus.bnd_first ? 0 : acc) + (bus.bnd_data[31] ? -1 : 1);
            if (bus.bnd_last) begin
                bus.bnd_done <= 1'b0;
                dly <= 3;
            end
        end else if (!bus.bnd_done && !stuck) begin
            if (dly == 0) begin
                bus.bnd_done   <= 1'b1;
                bus.bnd_result <= acc > 0 ? 32'h4000_0000 : acc < 0 ? 32'hC000_0000 : 32'h0;
            end else dly <= dly - 1;
        end
    end

    int          valid_cnt, wr_cnt, done_cnt, consec, noready, last_drop, last_wr_cyc, last_valid_cyc;
    logic [7:0]  signs, firsts, lasts, wr_addrs;
    logic [31:0] addrs, word2;
    logic [31:0] wr_d [2];
    bit          prev_valid, tail;

    always @(negedge clk) begin
        if (bus.mem_rd_en) addrs = {addrs[27:0], bus.mem_addr[3:0]};
        if (bus.bnd_valid) begin
            if (prev_valid) consec++;
            if (!bus.bnd_ready) noready++;
            if (valid_cnt == 2) word2 = bus.bnd_data;
            signs  = {signs[6:0], bus.bnd_data[31]};
            firsts = {firsts[6:0], bus.bnd_first};
            lasts  = {lasts[6:0], bus.bnd_last};
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        if (tail && !bus.bnd_last) last_drop++;
        if (bus.bnd_valid && bus.bnd_last) tail = 1;
        if (bus.res_wr_en) begin
            if (wr_cnt < 2) wr_d[wr_cnt] = bus.res_data;
            wr_addrs = {wr_addrs[3:0], bus.res_addr[3:0]};
            wr_cnt++;
            last_wr_cyc = cyc;
            tail = 0;
        end
        if (bus.done_all) done_cnt++;
        prev_valid = bus.bnd_valid;
    end

    task automatic clear_log();
        valid_cnt = 0; wr_cnt = 0; done_cnt = 0; consec = 0; noready = 0; last_drop = 0;
        signs = '0; firsts = '0; lasts = '0; wr_addrs = '0; addrs = '0; word2 = '0;
        wr_d[0] = '0; wr_d[1] = '0; prev_valid = 0; tail = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            tick(1);
            got = bus.done_all;
        end
    endtask

    task automatic wait_valids(input int n, input int budget, output bit got);
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            tick(1);
            got = valid_cnt >= n;
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({bus.busy, bus.done_all, bus.err, bus.mem_rd_en, bus.mem_addr, bus.bnd_valid,
                     bus.bnd_first, bus.bnd_last, bus.bnd_data, bus.res_wr_en, bus.res_addr, bus.res_data});
    endfunction

    task automatic check_results(input string tag);
        check({tag, "_wr_cnt"}, 128'(wr_cnt), 128'(2));
        check({tag, "_wr_addrs"}, 128'(wr_addrs), 128'(8'h01));
        check({tag, "_res0"}, 128'(wr_d[0]), 128'(32'h4000_0000));
        check({tag, "_res1"}, 128'(wr_d[1]), 128'(32'hC000_0000));
        check({tag, "_mem_addrs"}, 128'(addrs), 128'(32'h0246_1357));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        clear_log();
        tick(3);
        check("reset_outputs", outs(), '0);
        reset_n = 1'b1;
        tick(2);

        // Basic run with ready always high.
        clear_log();
        pulse_start();
        wait_done(200, ok);
        check("run1_done_seen", 128'(ok), 128'(1));
        check("run1_busy_at_done", 128'(bus.busy), 128'(0));
        check("run1_done_after_write", 128'(cyc - last_wr_cyc), 128'(1));
        check("run1_err", 128'(bus.err), 128'(0));
        tick(1);
        check("run1_done_width", 128'(bus.done_all), 128'(0));
        check_results("run1");
        check("run1_valid_cnt", 128'(valid_cnt), 128'(8));
        check("run1_firsts", 128'(firsts), 128'(8'b1000_1000));
        check("run1_lasts", 128'(lasts), 128'(8'b0001_0001));
        check("run1_signs", 128'(signs), 128'(8'b0010_1011));
        check("run1_word2", 128'(word2), 128'(N1));
        check("run1_consecutive_valid", 128'(consec), 128'(0));
        check("run1_last_held", 128'(last_drop), 128'(0));

        // Ready stall in ISSUE, plus a start pulse while busy.
        clear_log();
        ready_block = 1'b1;
        pulse_start();
        tick(14);
        check("stall_no_valid", 128'(valid_cnt), 128'(0));
        check("stall_busy", 128'(bus.busy), 128'(1));
        ready_block = 1'b0;
        tick(5);
        pulse_start();
        wait_done(300, ok);
        check("stall_done_seen", 128'(ok), 128'(1));
        tick(20);
        check_results("stall");
        check("stall_valid_cnt", 128'(valid_cnt), 128'(8));
        check("stall_valid_without_ready", 128'(noready), 128'(0));
        check("stall_consecutive_valid", 128'(consec), 128'(0));
        check("stall_done_cnt", 128'(done_cnt), 128'(1));
        check("stall_idle_after", 128'(bus.busy), 128'(0));

        // Reset while waiting for the bundler result.
        clear_log();
        stuck = 1'b1;
        pulse_start();
        wait_valids(4, 100, ok);
        check("rst_reach_last_word", 128'(ok), 128'(1));
        tick(3);
        check("rst_busy_in_wait", 128'(bus.busy), 128'(1));
        check("rst_last_held", 128'(bus.bnd_last), 128'(1));
        check("rst_last_drop", 128'(last_drop), 128'(0));
`ifndef BUNDLE_SEQ_TIMEOUT_EN
        tick(40);
        check("nowd_still_busy", 128'(bus.busy), 128'(1));
        check("nowd_err", 128'(bus.err), 128'(0));
`endif
        reset_n = 1'b0;
        #1;
        check("rst_outputs", outs(), '0);
        tick(2);
        reset_n = 1'b1;
        stuck = 1'b0;
        clear_log();
        tick(20);
        check("rst_no_write_after", 128'(wr_cnt), 128'(0));
        check("rst_no_done_after", 128'(done_cnt), 128'(0));
        pulse_start();
        wait_done(200, ok);
        check("rst_rerun_done_seen", 128'(ok), 128'(1));
        tick(1);
        check_results("rst_rerun");

`ifdef BUNDLE_SEQ_TIMEOUT_EN
        clear_log();
        stuck = 1'b1;
        pulse_start();
        wait_done(200, ok);
        check("wd_done_seen", 128'(ok), 128'(1));
        check("wd_latency", 128'(cyc - last_valid_cyc), 128'(23));
        check("wd_err", 128'(bus.err), 128'(1));
        check("wd_idle", 128'(bus.busy), 128'(0));
        check("wd_last_cleared", 128'(bus.bnd_last), 128'(0));
        check("wd_no_write", 128'(wr_cnt), 128'(0));
        tick(3);
        check("wd_err_sticky", 128'(bus.err), 128'(1));
        stuck = 1'b0;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
        clear_log();
        pulse_start();
        check("wd_err_cleared_by_start", 128'(bus.err), 128'(0));
        wait_done(200, ok);
        check("wd_rerun_done_seen", 128'(ok), 128'(1));
        tick(1);
        check_results("wd_rerun");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bundle_element_sequencer.md
Name: bundle_element_sequencer

Overview:
- Upstream feeder for the bipolar element-wise add-and-cut bundler.
- Bundles NUM_HV stored hypervectors one element index at a time: reads element e of vector 0..NUM_HV-1 from a read-only HV memory and streams them to the bundler with valid/first/last.
- Captures the cut result and writes it to a result memory at address e, for e = 0..HV_DIM-1.

Parameters:
- HV_DATA_WIDTH, 32, width of one FP32 element.
- NUM_HV, 4, vectors bundled per element; legal range is >= 2.
- HV_DIM, 64, elements per hypervector.
- ADDR_WIDTH, 16, width of the HV memory and result memory address buses.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- start  in  1  one-cycle pulse that begins a bundling run
- busy  out  1  high while a run is in progress
- done_all  out  1  one-cycle pulse when the run finishes
- err  out  1  sticky timeout flag
- mem_rd_en  out  1  HV memory read strobe
- mem_addr  out  ADDR_WIDTH  read address = v*HV_DIM + e
- mem_rd_data  in  HV_DATA_WIDTH  read data, valid 1 cycle after mem_rd_en
- bnd_valid  out  1  word valid to bundler
- bnd_first  out  1  first word of an element group
- bnd_last  out  1  last word of an element group
- bnd_data  out  HV_DATA_WIDTH  word to bundler
- bnd_ready  in  1  bundler can accept a word
- bnd_done  in  1  bundler idle/result available
- bnd_result  in  HV_DATA_WIDTH  bundler cut output
- res_wr_en  out  1  result write strobe
- res_addr  out  ADDR_WIDTH  result address = e
- res_data  out  HV_DATA_WIDTH  result word

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, counters v=0, e=0, err=0.
- States:
  - IDLE: on start, go to FETCH. busy=0.
  - FETCH: mem_rd_en=1 for one cycle with mem_addr = v*HV_DIM+e; go to LOAD.
  - LOAD: register mem_rd_data into bnd_data. Set bnd_first=(v==0) and bnd_last=(v==NUM_HV-1). Go to ISSUE.
  - ISSUE: wait for bnd_ready=1. In that cycle drive bnd_valid=1 for exactly that cycle. Then go to GAP.
  - GAP: one mandatory dead cycle, because bundler ready is registered and lags one cycle. If v<NUM_HV-1: v++, go to FETCH. Else go to WAIT_LOW.
  - WAIT_LOW: wait for bnd_done==0, which confirms the bundler left idle; go to WAIT_RES.
  - WAIT_RES: wait for bnd_done==1; capture bnd_result into res_data; go to WRITE.
  - WRITE: res_wr_en=1 for one cycle with res_addr=e. Then v=0. If e==HV_DIM-1: pulse done_all and go to IDLE. Else e++ and go to FETCH.
- bnd_first, bnd_last and bnd_data are held stable from LOAD until the next LOAD. The bundler samples last several cycles after valid, so bnd_last must remain high through WAIT_RES.
- busy=1 in every state except IDLE. start while busy is ignored.
- Per-element latency: NUM_HV*(4 + ready stall) cycles, plus the bundler result time, plus 1 write cycle.
- Address arithmetic: unsigned, truncated to ADDR_WIDTH. The requirement NUM_HV*HV_DIM <= 2^ADDR_WIDTH is a decided requirement, checked by an elaboration-time assertion.
- Reset mid-run: abort immediately, with no partial write or pulse after reset release.

Optional Feature:
- Macro: BUNDLE_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs in ISSUE, WAIT_LOW and WAIT_RES, and clears on every state change.
  - When it reaches TIMEOUT_CYCLES, err is set (sticky until reset or the next start), the bnd_* outputs are cleared, done_all pulses, and the FSM goes to IDLE.
- Without the macro: no counter is built, err is tied 0, and the FSM waits indefinitely.

Decomposition:
- Shared package bundle_seq_pkg holds:
  - the state enum type BundleSeq_State_t (IDLE, FETCH, LOAD, ISSUE, GAP, WAIT_LOW, WAIT_RES, WRITE);
  - the address-compute function.
- No sub-module. The address generator is a small in-line counter pair (v, e).

Test Plan:
- Basic bundling: NUM_HV=4, HV_DIM=2, mem elements +1.0/+1.0/-1.0/+1.0 (0x3F800000/0xBF800000), bundler model with result 2.0 -> res_wr_en pulses twice, res_addr 0 then 1, done_all one cycle after the second write, busy falls the same cycle.
- Handshake: bnd_ready held low 10 cycles in ISSUE -> bnd_valid stays 0 throughout, then asserts for exactly 1 cycle; never on consecutive cycles.
- Qualifiers: bnd_first=1 only with v=0 words; bnd_last=1 on the v=3 word and held through WAIT_RES; mem_addr sequence 0,2,4,6,1,3,5,7 for HV_DIM=2.
- Start while busy: start pulsed mid-run -> no restart, total writes = HV_DIM.
- Reset mid-run: reset_n low during WAIT_RES -> all outputs 0 and no res_wr_en after release; a new start runs a full correct sequence from e=0.
- Timeout (BUNDLE_SEQ_TIMEOUT_EN defined): bnd_done held 0 forever, TIMEOUT_CYCLES=20 -> err=1 after 20 cycles in WAIT_RES, done_all pulses, IDLE; without the macro, err stays 0 and busy stays 1.
